mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access stage controller sitting between the execute stage and write-back. It consumes the load/store request that execute produces (effective address, store data, destination register, access size) and performs it over the CPU's byte-wide, single-port RAM bus as a multi-cycle byte-serial sequence. It returns sign- or zero-extended load data with its destination register to write-back, and holds off the pipeline while an access is in flight.

## Interface
Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, register / load-store data width; must equal 4 × 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy_i  in  1  memory bus ready; low freezes the unit.
- req_valid_i  in  1  execute presents a memory request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word.
- req_signed_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr_i  in  ADDR_W  effective address, execute's base + offset.
- req_wdata_i  in  DATA_W  store data, low bytes used.
- req_wd_i  in  5  destination register.
- req_wreg_i  in  1  load writes a register.
- busy_o  out  1  request cannot be accepted; execute/decode stall.
- mem_a_o  out  ADDR_W  RAM byte address.
- mem_dout_o  out  8  RAM write byte.
- mem_wr_o  out  1  RAM write strobe.
- mem_din_i  in  8  RAM read byte, valid one cycle after its address.
- done_o  out  1  one-cycle pulse: access complete.
- wd_o  out  5  write-back register.
- wreg_o  out  1  write-back enable.
- wdata_o  out  DATA_W  write-back data.

## Operation
- N = 1, 2 or 4 bytes from req_size_i. Byte k lives at req_addr + k, little-endian. Address add is modulo 2^ADDR_W, so 0xFFFF_FFFF + 1 = 0. No alignment check.
- States: IDLE, LOAD, STORE, DONE.
- IDLE: busy_o = 0. On req_valid_i && rdy_i, latch all req_* and set k = 0. Go to LOAD or STORE.
- LOAD:
  - Each active cycle drives mem_a_o = addr + k with mem_wr_o = 0.
  - mem_din_i is captured into byte k−1 of the assembly register for k ≥ 1.
  - After address N−1 is issued, one more active cycle captures the last byte, then the unit goes to DONE.
- STORE: each active cycle drives mem_a_o = addr + k, mem_dout_o = wdata[8k+7:8k], mem_wr_o = 1. After byte N−1 is written, go to DONE.
- DONE (one cycle):
  - done_o = 1, wd_o = latched wd.
  - Loads: wdata_o = assembled data, extended from bit 8N−1 per the signed flag; wreg_o = latched wreg && wd != 0.
  - Stores: wreg_o = 0 and wdata_o = 0.
  - Next state is IDLE.
- busy_o = 1 in LOAD, STORE and DONE.
- Outside DONE: done_o = 0, wreg_o = 0, wdata_o = 0, wd_o = 0.
- rdy_i low: state, k and capture are frozen; mem_wr_o forced 0; mem_a_o holds. A read byte is only captured on a cycle where the previous cycle was also rdy_i-high.
- req_valid_i while busy_o = 1 is ignored; execute must hold the request.

## Timing
- All outputs registered except busy_o, which is decoded from state.
- Reset (async, rst_n = 0): state IDLE, k = 0. All outputs 0: busy_o, mem_a_o, mem_dout_o, mem_wr_o, done_o, wd_o, wreg_o, wdata_o. Asserting reset mid-access aborts it immediately with no further writes; partial stores remain in RAM.
- Cycle numbering: request accepted at the edge ending cycle 0, with rdy_i high throughout.
- Load, N bytes: addresses on cycles 1..N; data bytes arrive cycles 2..N+1; done_o in cycle N+2. Word load done on cycle 6; byte load on cycle 3.
- Store, N bytes: mem_wr_o on cycles 1..N; done_o in cycle N+1.
- Earliest next acceptance is the cycle after DONE.
- Each rdy_i-low cycle adds exactly one cycle of latency.

## Test plan
- Word load, unsigned, at 0x100 holding bytes 78 56 34 12 → mem_a_o 0x100..0x103 on cycles 1-4; done_o on cycle 6 with wdata_o = 0x12345678, wd_o = 5, wreg_o = 1.
- Signed byte load of 0x80 → wdata_o = 0xFFFF_FF80. Unsigned half load of 0x8001 → wdata_o = 0x0000_8001. Load with wd = 0 → wreg_o = 0.
- Half store of 0xDEADBEEF at 0x20 → writes EF@0x20, BE@0x21 on cycles 1-2, nothing else; done_o on cycle 3 with wreg_o = 0.
- Word load at 0xFFFF_FFFE → addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1.
- Word store with rdy_i low on cycle 2 → byte 1 is not written that cycle, mem_wr_o = 0; done_o on cycle 6. Word load with rdy_i low on cycle 3 → data still correct; done_o on cycle 7.
- Assert rst_n low during cycle 2 of a word store → all outputs 0 immediately; only byte 0 written; a request after reset release completes normally. A back-to-back second request held during busy_o is accepted the cycle after done_o.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage: runs execute's load/store as a byte-serial sequence on the
// single-port byte RAM bus and hands extended load data to write-back.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy_i,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [4:0]        req_wd_i,
    input  logic              req_wreg_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o,
    input  logic [7:0]        mem_din_i,
    output logic              done_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o
);

    localparam int unsigned K_W = 3;

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_e;

    state_e            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [K_W-1:0]    last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [4:0]        rwd_q, rwd_d;
    logic              rwreg_q, rwreg_d;
    logic              rdy_q;

    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              done_q, done_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [K_W-1:0]    k_inc;
    logic [1:0]        cap_idx;

    function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] d, input logic [1:0] idx);
        byte_of = d[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] size, input logic sgn);
        unique case (size)
            2'b00:   extend = {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
            2'b01:   extend = {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    assign k_inc   = k_q + 3'd1;
    assign cap_idx = 2'(k_q - 3'd1);

    // Next-state, latched request and registered-output computation
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        last_d     = last_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        rwd_d      = rwd_q;
        rwreg_d    = rwreg_q;
        asm_d      = asm_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        done_d     = 1'b0;
        wd_d       = 5'd0;
        wreg_d     = 1'b0;
        wdata_d    = '0;

        // Byte for address k-1 arrives now if the cycle that issued it was not stalled
        if (state_q == LOAD && k_q != 3'd0 && rdy_q) begin
            asm_d[{cap_idx, 3'b000} +: 8] = mem_din_i;
        end

        unique case (state_q)
            IDLE: begin
                mem_wr_d = 1'b0;
                if (req_valid_i && rdy_i) begin
                    addr_d     = req_addr_i;
                    sdata_d    = req_wdata_i;
                    size_d     = req_size_i;
                    sgn_d      = req_signed_i;
                    rwd_d      = req_wd_i;
                    rwreg_d    = req_wreg_i;
                    asm_d      = '0;
                    k_d        = 3'd0;
                    last_d     = (req_size_i == 2'b00) ? 3'd0 :
                                 (req_size_i == 2'b01) ? 3'd1 : 3'd3;
                    mem_a_d    = req_addr_i;
                    mem_dout_d = req_wdata_i[7:0];
                    mem_wr_d   = req_we_i;
                    state_d    = req_we_i ? STORE : LOAD;
                end
            end
            LOAD: begin
                if (rdy_i) begin
                    if (k_q == last_q + 3'd1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        wd_d    = rwd_q;
                        wreg_d  = rwreg_q && (rwd_q != 5'd0);
                        wdata_d = extend(asm_d, size_q, sgn_q);
                    end else begin
                        k_d = k_inc;
                        if (k_q != last_q) begin
                            mem_a_d = addr_q + ADDR_W'(k_inc);
                        end
                    end
                end
            end
            STORE: begin
                if (rdy_i) begin
                    if (k_q == last_q) begin
                        state_d  = DONE;
                        mem_wr_d = 1'b0;
                        done_d   = 1'b1;
                        wd_d     = rwd_q;
                    end else begin
                        k_d        = k_inc;
                        mem_a_d    = addr_q + ADDR_W'(k_inc);
                        mem_dout_d = byte_of(sdata_q, k_inc[1:0]);
                        mem_wr_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            last_q     <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            rwd_q      <= '0;
            rwreg_q    <= 1'b0;
            asm_q      <= '0;
            rdy_q      <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            rwd_q      <= rwd_d;
            rwreg_q    <= rwreg_d;
            asm_q      <= asm_d;
            rdy_q      <= rdy_i;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            done_q     <= done_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign mem_a_o    = mem_a_q;
    assign mem_dout_o = mem_dout_q;
    // A stalled bus cycle must never strobe a write
    assign mem_wr_o   = mem_wr_q & rdy_i;
    assign done_o     = done_q;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte RAM model whose read data lags the address by one cycle.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        rdy_i;
    logic        req_valid_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_wd_i;
    logic        req_wreg_i;
    logic        busy_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic [7:0]  mem_din_i;
    logic        done_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rdy_i(rdy_i),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_signed_i(req_signed_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_wd_i(req_wd_i), .req_wreg_i(req_wreg_i), .busy_o(busy_o),
        .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o),
        .mem_din_i(mem_din_i), .done_o(done_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model, indexed by the low address byte; preload port shares the write path
    logic [7:0] ram [256];
    logic       pl_en;
    logic [7:0] pl_a;
    logic [7:0] pl_d;
    always @(posedge clk) begin
        mem_din_i <= ram[mem_a_o[7:0]];
        if (pl_en) ram[pl_a] <= pl_d;
        else if (mem_wr_o) ram[mem_a_o[7:0]] <= mem_dout_o;
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] a_log  [16];
    logic        wr_log [16];
    logic        bz_log [16];
    logic [31:0] wa_log [8];
    logic [7:0]  wb_log [8];
    int          n_wr;
    int          done_cyc;
    logic [31:0] done_data;
    logic [4:0]  done_wd;
    logic        done_wreg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic poke32(input logic [7:0] a, input logic [31:0] w);
        poke(a, w[7:0]);
        poke(8'(a + 8'd1), w[15:8]);
        poke(8'(a + 8'd2), w[23:16]);
        poke(8'(a + 8'd3), w[31:24]);
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] wd, input logic wreg);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_signed_i = sgn;
        req_addr_i = addr; req_wdata_i = wdata; req_wd_i = wd; req_wreg_i = wreg;
    endtask

    // Issue one request in cycle 0 and log 15 following cycles; rdy_i is low in cycle 'stall'
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] wd, input logic wreg, input int stall);
        @(posedge clk); #1;
        rdy_i = 1'b1;
        drive_req(we, size, sgn, addr, wdata, wd, wreg);
        n_wr = 0; done_cyc = 0; done_data = '0; done_wd = '0; done_wreg = 1'b0;
        for (int c = 1; c < 16; c++) begin
            @(posedge clk); #1;
            req_valid_i = 1'b0;
            rdy_i = (c != stall);
            @(negedge clk);
            a_log[c] = mem_a_o; wr_log[c] = mem_wr_o; bz_log[c] = busy_o;
            if (mem_wr_o && n_wr < 8) begin
                wa_log[n_wr] = mem_a_o; wb_log[n_wr] = mem_dout_o; n_wr++;
            end
            if (done_o && done_cyc == 0) begin
                done_cyc = c; done_data = wdata_o; done_wd = wd_o; done_wreg = wreg_o;
            end
        end
        rdy_i = 1'b1;
    endtask

    int          d1, d2;
    logic [31:0] d2_data;
    logic [4:0]  d2_wd;
    logic        d2_wreg;
    logic        acc2;

    initial begin
        rst_n = 1'b0; rdy_i = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = '0; req_signed_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; req_wd_i = '0; req_wreg_i = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        #12;
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_mem_a", mem_a_o, 32'd0);
        check("rst_dout",  32'(mem_dout_o), 32'd0);
        check("rst_wr",    32'(mem_wr_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_wd",    32'(wd_o), 32'd0);
        check("rst_wreg",  32'(wreg_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Word load, unsigned
        poke32(8'h00, 32'h12345678);
        run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1, 0);
        check("wl_a1", a_log[1], 32'h100);
        check("wl_a2", a_log[2], 32'h101);
        check("wl_a3", a_log[3], 32'h102);
        check("wl_a4", a_log[4], 32'h103);
        check("wl_busy1", 32'(bz_log[1]), 32'd1);
        check("wl_nwr", 32'(n_wr), 32'd0);
        check("wl_cyc", 32'(done_cyc), 32'd6);
        check("wl_data", done_data, 32'h12345678);
        check("wl_wd", 32'(done_wd), 32'd5);
        check("wl_wreg", 32'(done_wreg), 32'd1);
        check("wl_idle", 32'(bz_log[7]), 32'd0);

        // Signed byte load
        poke(8'h10, 8'h80);
        run_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 5'd3, 1'b1, 0);
        check("bl_cyc", 32'(done_cyc), 32'd3);
        check("bl_data", done_data, 32'hFFFF_FF80);

        // Unsigned half load
        poke(8'h30, 8'h01); poke(8'h31, 8'h80);
        run_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 5'd9, 1'b1, 0);
        check("hl_cyc", 32'(done_cyc), 32'd4);
        check("hl_data", done_data, 32'h0000_8001);

        // Load to register 0 never writes back
        run_req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 5'd0, 1'b1, 0);
        check("r0_wreg", 32'(done_wreg), 32'd0);
        check("r0_data", done_data, 32'hFFFF_8001);

        // Half store
        poke(8'h22, 8'h55);
        run_req(1'b1, 2'b01, 1'b0, 32'h20, 32'hDEADBEEF, 5'd4, 1'b1, 0);
        check("hs_nwr", 32'(n_wr), 32'd2);
        check("hs_a0", wa_log[0], 32'h20);
        check("hs_d0", 32'(wb_log[0]), 32'hEF);
        check("hs_a1", wa_log[1], 32'h21);
        check("hs_d1", 32'(wb_log[1]), 32'hBE);
        check("hs_wr2", 32'(wr_log[2]), 32'd1);
        check("hs_cyc", 32'(done_cyc), 32'd3);
        check("hs_wreg", 32'(done_wreg), 32'd0);
        check("hs_wdata", done_data, 32'd0);
        check("hs_ram22", 32'(ram[8'h22]), 32'h55);

        // Address wrap
        poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33); poke(8'h01, 8'h44);
        run_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 5'd1, 1'b1, 0);
        check("wr_a1", a_log[1], 32'hFFFF_FFFE);
        check("wr_a2", a_log[2], 32'hFFFF_FFFF);
        check("wr_a3", a_log[3], 32'h0);
        check("wr_a4", a_log[4], 32'h1);
        check("wr_data", done_data, 32'h44332211);

        // Word store with rdy_i low in cycle 2
        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hA1B2C3D4, 5'd2, 1'b0, 2);
        check("ss_wr2", 32'(wr_log[2]), 32'd0);
        check("ss_nwr", 32'(n_wr), 32'd4);
        check("ss_cyc", 32'(done_cyc), 32'd6);
        check("ss_ram", {ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]}, 32'hA1B2C3D4);

        // Word load with rdy_i low in cycle 3
        poke32(8'h00, 32'h12345678);
        run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd6, 1'b1, 3);
        check("sl_cyc", 32'(done_cyc), 32'd7);
        check("sl_data", done_data, 32'h12345678);

        // Reset during cycle 2 of a word store
        poke32(8'h50, 32'hAAAAAAAA);
        @(posedge clk); #1;
        drive_req(1'b1, 2'b10, 1'b0, 32'h50, 32'h11223344, 5'd2, 1'b0);
        @(posedge clk); #1; req_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("ar_busy", 32'(busy_o), 32'd0);
        check("ar_wr", 32'(mem_wr_o), 32'd0);
        check("ar_a", mem_a_o, 32'd0);
        check("ar_dout", 32'(mem_dout_o), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check("ar_ram", {ram[8'h53], ram[8'h52], ram[8'h51], ram[8'h50]}, 32'hAAAAAA44);
        rst_n = 1'b1;
        run_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 5'd8, 1'b1, 0);
        check("ar_ld_cyc", 32'(done_cyc), 32'd6);
        check("ar_ld_data", done_data, 32'hAAAAAA44);

        // Back-to-back: byte store, then a load held while busy
        @(posedge clk); #1;
        drive_req(1'b1, 2'b00, 1'b0, 32'h60, 32'h0000005A, 5'd0, 1'b0);
        d1 = 0; d2 = 0; d2_data = '0; d2_wd = '0; d2_wreg = 1'b0; acc2 = 1'b0;
        for (int c = 1; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive_req(1'b0, 2'b00, 1'b0, 32'h60, 32'h0, 5'd7, 1'b1);
            if (acc2) req_valid_i = 1'b0;
            @(negedge clk);
            a_log[c] = mem_a_o; bz_log[c] = busy_o;
            if (done_o) begin
                if (d1 == 0) d1 = c;
                else if (d2 == 0) begin d2 = c; d2_data = wdata_o; d2_wd = wd_o; d2_wreg = wreg_o; end
            end
            if (!busy_o && req_valid_i) acc2 = 1'b1;
        end
        req_valid_i = 1'b0;
        check("bb_d1", 32'(d1), 32'd2);
        check("bb_busy2", 32'(bz_log[2]), 32'd1);
        check("bb_busy3", 32'(bz_log[3]), 32'd0);
        check("bb_a4", a_log[4], 32'h60);
        check("bb_d2", 32'(d2), 32'd6);
        check("bb_data", d2_data, 32'h5A);
        check("bb_wd", 32'(d2_wd), 32'd7);
        check("bb_wreg", 32'(d2_wreg), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
